// File: rtl/ocx_tlx_parser_err_log_if.sv
// Error-capture bus between the TLX parser error detectors/firmware and the error logger.
// OCX_TLX_ERR_LOG_TIMESTAMP_EN adds the log and first-error timestamp signals.
interface ocx_tlx_parser_err_log_if #(
    parameter int unsigned NUM_ERR = 8,
    parameter int unsigned INFO_W  = 28,
    parameter int unsigned CNT_W   = 8
);
    logic [NUM_ERR-1:0]        err_vec;
    logic [NUM_ERR*INFO_W-1:0] err_info;
    logic [NUM_ERR-1:0]        err_enable;
    logic [NUM_ERR-1:0]        err_fatal_mask;
    logic                      err_clear;
    logic                      log_rd;
    logic                      log_valid;
    logic [31:0]               log_data;
    logic                      log_overflow;
    logic [CNT_W-1:0]          drop_count;
    logic                      first_err_valid;
    logic [31:0]               first_err_data;
    logic [31:0]               rcv_xmt_debug_info;
    logic                      rcv_xmt_debug_valid;
    logic                      rcv_xmt_debug_fatal;
`ifdef OCX_TLX_ERR_LOG_TIMESTAMP_EN
    logic [15:0]               log_timestamp;
    logic [15:0]               first_err_timestamp;
`endif

    modport master (
        output err_vec, err_info, err_enable, err_fatal_mask, err_clear, log_rd,
        input  log_valid, log_data, log_overflow, drop_count, first_err_valid,
               first_err_data, rcv_xmt_debug_info, rcv_xmt_debug_valid, rcv_xmt_debug_fatal
`ifdef OCX_TLX_ERR_LOG_TIMESTAMP_EN
        , input log_timestamp, first_err_timestamp
`endif
    );

    modport slave (
        input  err_vec, err_info, err_enable, err_fatal_mask, err_clear, log_rd,
        output log_valid, log_data, log_overflow, drop_count, first_err_valid,
               first_err_data, rcv_xmt_debug_info, rcv_xmt_debug_valid, rcv_xmt_debug_fatal
`ifdef OCX_TLX_ERR_LOG_TIMESTAMP_EN
        , output log_timestamp, first_err_timestamp
`endif
    );
endinterface

// File: rtl/ocx_tlx_parser_err_log.sv
// TLX receive-parser error logger: priority select, debug triple, first-error capture and FWFT log FIFO.
// Optional macro OCX_TLX_ERR_LOG_TIMESTAMP_EN timestamps every log entry and the first error.
module ocx_tlx_parser_err_log #(
    parameter int unsigned NUM_ERR    = 8,
    parameter int unsigned INFO_W     = 28,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                          tlx_clk,
    input  logic                          reset,
    ocx_tlx_parser_err_log_if.slave       bus
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [NUM_ERR-1:0]        s1_vec_q, s1_fatal_q;
    logic [NUM_ERR*INFO_W-1:0] s1_info_q;
    logic [PW-1:0]             rd_q, rd_d, wr_q, wr_d;
    logic [31:0]               mem_q [FIFO_DEPTH];
    logic                      log_valid_q, log_valid_d;
    logic [31:0]               log_data_q, log_data_d;
    logic                      ovf_q, ovf_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      fv_q, fv_d;
    logic [31:0]               fd_q, fd_d;
    logic                      dv_q, dv_d;
    logic [31:0]               di_q, di_d;
    logic                      fatal_q, fatal_d;
    logic                      sel_valid, sel_fatal;
    logic [31:0]               sel_data;
    logic                      empty, full, pop, push, drop, fwd;
`ifdef OCX_TLX_ERR_LOG_TIMESTAMP_EN
    logic [15:0]               ts_q, ts_d, log_ts_q, log_ts_d, first_ts_q, first_ts_d;
    logic [15:0]               ts_mem_q [FIFO_DEPTH];
`endif

    // Lowest asserted index wins; code is index+1, info zero-extended to 28 bits.
    always_comb begin
        sel_valid = 1'b0;
        sel_fatal = 1'b0;
        sel_data  = '0;
        for (int unsigned i = 0; i < NUM_ERR; i++) begin
            if (s1_vec_q[i] && !sel_valid) begin
                sel_valid = 1'b1;
                sel_fatal = s1_fatal_q[i];
                sel_data  = {28'(s1_info_q[i*INFO_W +: INFO_W]), 4'(i + 1)};
            end
        end
    end

    always_comb begin
        empty = (wr_q == rd_q);
        full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
        pop   = bus.log_rd && !empty;
        push  = sel_valid && (!full || pop);
        drop  = sel_valid && full && !pop;
        rd_d  = rd_q + PW'(pop);
        wr_d  = wr_q + PW'(push);
        // Entry written this edge becomes the head when it is the only one left.
        fwd         = push && (rd_d[AW-1:0] == wr_q[AW-1:0]);
        log_valid_d = (wr_d != rd_d);
        log_data_d  = '0;
        if (log_valid_d) log_data_d = fwd ? sel_data : mem_q[rd_d[AW-1:0]];

        ovf_d = bus.err_clear ? 1'b0 : ovf_q;
        cnt_d = bus.err_clear ? '0 : cnt_q;
        if (drop) begin
            ovf_d = 1'b1;
            if (cnt_d != {CNT_W{1'b1}}) cnt_d = cnt_d + CNT_W'(1);
        end

        fv_d = fv_q;
        fd_d = fd_q;
        if (sel_valid && (!fv_q || bus.err_clear)) begin
            fv_d = 1'b1;
            fd_d = sel_data;
        end else if (bus.err_clear) begin
            fv_d = 1'b0;
            fd_d = '0;
        end

        dv_d    = sel_valid;
        di_d    = sel_valid ? sel_data : di_q;
        fatal_d = fatal_q | (sel_valid & sel_fatal);
`ifdef OCX_TLX_ERR_LOG_TIMESTAMP_EN
        ts_d       = ts_q + 16'd1;
        log_ts_d   = '0;
        if (log_valid_d) log_ts_d = fwd ? ts_q : ts_mem_q[rd_d[AW-1:0]];
        first_ts_d = first_ts_q;
        if (sel_valid && (!fv_q || bus.err_clear)) first_ts_d = ts_q;
        else if (bus.err_clear)                    first_ts_d = '0;
`endif
    end

    always_ff @(posedge tlx_clk) begin
        if (reset) begin
            s1_vec_q    <= '0;
            s1_fatal_q  <= '0;
            s1_info_q   <= '0;
            rd_q        <= '0;
            wr_q        <= '0;
            log_valid_q <= 1'b0;
            log_data_q  <= '0;
            ovf_q       <= 1'b0;
            cnt_q       <= '0;
            fv_q        <= 1'b0;
            fd_q        <= '0;
            dv_q        <= 1'b0;
            di_q        <= '0;
            fatal_q     <= 1'b0;
`ifdef OCX_TLX_ERR_LOG_TIMESTAMP_EN
            ts_q        <= '0;
            log_ts_q    <= '0;
            first_ts_q  <= '0;
`endif
        end else begin
            s1_vec_q    <= bus.err_vec & bus.err_enable;
            s1_fatal_q  <= bus.err_fatal_mask;
            s1_info_q   <= bus.err_info;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            log_valid_q <= log_valid_d;
            log_data_q  <= log_data_d;
            ovf_q       <= ovf_d;
            cnt_q       <= cnt_d;
            fv_q        <= fv_d;
            fd_q        <= fd_d;
            dv_q        <= dv_d;
            di_q        <= di_d;
            fatal_q     <= fatal_d;
`ifdef OCX_TLX_ERR_LOG_TIMESTAMP_EN
            ts_q        <= ts_d;
            log_ts_q    <= log_ts_d;
            first_ts_q  <= first_ts_d;
`endif
        end
    end

    // Storage array needs no reset: pointers define which entries are live.
    always_ff @(posedge tlx_clk) begin
        if (push && !reset) begin
            mem_q[wr_q[AW-1:0]] <= sel_data;
`ifdef OCX_TLX_ERR_LOG_TIMESTAMP_EN
            ts_mem_q[wr_q[AW-1:0]] <= ts_q;
`endif
        end
    end

    assign bus.log_valid           = log_valid_q;
    assign bus.log_data            = log_data_q;
    assign bus.log_overflow        = ovf_q;
    assign bus.drop_count          = cnt_q;
    assign bus.first_err_valid     = fv_q;
    assign bus.first_err_data      = fd_q;
    assign bus.rcv_xmt_debug_info  = di_q;
    assign bus.rcv_xmt_debug_valid = dv_q;
    assign bus.rcv_xmt_debug_fatal = fatal_q;
`ifdef OCX_TLX_ERR_LOG_TIMESTAMP_EN
    assign bus.log_timestamp       = log_ts_q;
    assign bus.first_err_timestamp = first_ts_q;
`endif
endmodule

// File: tb/tb_ocx_tlx_parser_err_log.sv
// Directed and random bench for ocx_tlx_parser_err_log with a queue-based log scoreboard.
module tb_ocx_tlx_parser_err_log;
    localparam int unsigned NUM_ERR = 8;
    localparam int unsigned INFO_W  = 28;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned CNT_W   = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ocx_tlx_parser_err_log_if #(.NUM_ERR(NUM_ERR), .INFO_W(INFO_W), .CNT_W(CNT_W)) bus ();

    ocx_tlx_parser_err_log #(.NUM_ERR(NUM_ERR), .INFO_W(INFO_W), .FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .tlx_clk(clk),
        .reset  (rst),
        .bus    (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] sb[$];
    bit          p1_v, p1_f;
    logic [31:0] p1_d;
    bit          ovf_m, fv_m, dv_m, fat_m;
    int          drop_m;
    logic [31:0] fd_m, di_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("log_valid", 32'(bus.log_valid), 32'(sb.size() > 0));
        chk("log_data", bus.log_data, (sb.size() > 0) ? sb[0] : 32'h0);
        chk("log_overflow", 32'(bus.log_overflow), 32'(ovf_m));
        chk("drop_count", 32'(bus.drop_count), 32'(drop_m));
        chk("first_err_valid", 32'(bus.first_err_valid), 32'(fv_m));
        chk("first_err_data", bus.first_err_data, fd_m);
        chk("dbg_valid", 32'(bus.rcv_xmt_debug_valid), 32'(dv_m));
        chk("dbg_info", bus.rcv_xmt_debug_info, di_m);
        chk("dbg_fatal", 32'(bus.rcv_xmt_debug_fatal), 32'(fat_m));
    endtask

    // Advance one edge, updating the reference model with the inputs currently driven.
    task automatic step();
        bit          arr_v, arr_f, found;
        logic [31:0] arr_d;
        logic [7:0]  act;
        if (rst) begin
            sb.delete();
            p1_v = 0; p1_f = 0; p1_d = '0;
            ovf_m = 0; fv_m = 0; dv_m = 0; fat_m = 0; drop_m = 0; fd_m = '0; di_m = '0;
        end else begin
            arr_v = p1_v; arr_d = p1_d; arr_f = p1_f;
            if (bus.log_rd && sb.size() > 0) void'(sb.pop_front());
            if (bus.err_clear) begin ovf_m = 0; drop_m = 0; end
            if (arr_v) begin
                if (sb.size() < DEPTH) sb.push_back(arr_d);
                else begin
                    ovf_m = 1;
                    if (drop_m != 255) drop_m++;
                end
            end
            if (arr_v && (!fv_m || bus.err_clear)) begin fv_m = 1; fd_m = arr_d; end
            else if (bus.err_clear) begin fv_m = 0; fd_m = '0; end
            dv_m = arr_v;
            if (arr_v) di_m = arr_d;
            fat_m = fat_m | (arr_v & arr_f);
            act = bus.err_vec & bus.err_enable;
            found = 0; p1_f = 0; p1_d = '0;
            for (int i = 0; i < NUM_ERR; i++) begin
                if (act[i] && !found) begin
                    found = 1;
                    p1_f  = bus.err_fatal_mask[i];
                    p1_d  = {bus.err_info[i*INFO_W +: INFO_W], 4'(i + 1)};
                end
            end
            p1_v = found;
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        bus.err_vec = '0; bus.err_info = '0; bus.err_enable = 8'hFF;
        bus.err_fatal_mask = '0; bus.err_clear = 0; bus.log_rd = 0;
        rst = 1; step(); step(); rst = 0;
        chk("reset_log_valid", 32'(bus.log_valid), 32'h0);
        chk("reset_fatal", 32'(bus.rcv_xmt_debug_fatal), 32'h0);

        // Single error on source 2
        bus.err_vec = 8'h04; bus.err_info[2*INFO_W +: INFO_W] = 28'hABCDEF0;
        step();
        bus.err_vec = '0;
        chk("single_n1_valid", 32'(bus.rcv_xmt_debug_valid), 32'h0);
        step();
        chk("single_dbg_valid", 32'(bus.rcv_xmt_debug_valid), 32'h1);
        chk("single_dbg_info", bus.rcv_xmt_debug_info, 32'hABCDEF03);
        chk("single_log_data", bus.log_data, 32'hABCDEF03);
        chk("single_first", bus.first_err_data, 32'hABCDEF03);
        step();
        chk("single_pulse", 32'(bus.rcv_xmt_debug_valid), 32'h0);
        bus.log_rd = 1; step(); bus.log_rd = 0;
        bus.log_rd = 1; step(); bus.log_rd = 0;   // pop while empty is ignored

        // Priority with source 1 disabled
        bus.err_info = '0;
        bus.err_info[1*INFO_W +: INFO_W] = 28'h1111111;
        bus.err_info[3*INFO_W +: INFO_W] = 28'h3333333;
        bus.err_vec = 8'h0A; bus.err_enable = 8'hFD;
        step();
        bus.err_vec = '0; bus.err_enable = 8'hFF;
        step();
        chk("prio_info", bus.rcv_xmt_debug_info, 32'h33333334);
        bus.log_rd = 1; step(); bus.log_rd = 0;
        chk("prio_one_push", 32'(bus.log_valid), 32'h0);

        // Overflow: six errors into a four-deep log
        rst = 1; step(); rst = 0;
        for (int k = 0; k < 6; k++) begin
            bus.err_vec = 8'h01; bus.err_info[INFO_W-1:0] = 28'(k + 16);
            step();
        end
        bus.err_vec = '0;
        step(); step();
        chk("ovf_flag", 32'(bus.log_overflow), 32'h1);
        chk("ovf_drops", 32'(bus.drop_count), 32'h2);
        chk("ovf_head", bus.log_data, 32'h00000101);
        bus.err_clear = 1; step(); bus.err_clear = 0;
        chk("clr_drops", 32'(bus.drop_count), 32'h0);
        chk("clr_flag", 32'(bus.log_overflow), 32'h0);
        chk("clr_log_valid", 32'(bus.log_valid), 32'h1);

        // Full log: pop and push on the same edge
        bus.err_vec = 8'h10; bus.err_info[4*INFO_W +: INFO_W] = 28'h1234567;
        step();
        bus.err_vec = '0; bus.log_rd = 1;
        step();
        bus.log_rd = 0;
        chk("fpp_no_drop", 32'(bus.drop_count), 32'h0);
        bus.log_rd = 1; step(); step(); step();
        chk("fpp_tail", bus.log_data, 32'h12345675);
        step(); bus.log_rd = 0;
        chk("fpp_drained", 32'(bus.log_valid), 32'h0);

        // Fatal stickiness
        rst = 1; step(); rst = 0;
        bus.err_fatal_mask = 8'h01; bus.err_vec = 8'h01;
        step();
        bus.err_vec = '0;
        chk("fatal_n1", 32'(bus.rcv_xmt_debug_fatal), 32'h0);
        step();
        chk("fatal_n2", 32'(bus.rcv_xmt_debug_fatal), 32'h1);
        bus.err_clear = 1; step(); bus.err_clear = 0;
        chk("fatal_after_clear", 32'(bus.rcv_xmt_debug_fatal), 32'h1);
        rst = 1; step(); rst = 0;
        chk("fatal_after_reset", 32'(bus.rcv_xmt_debug_fatal), 32'h0);

        // Random traffic with reset in mid-operation
        for (int c = 0; c < 200; c++) begin
            bus.err_vec        = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
            bus.err_enable     = 8'($urandom) | 8'hF0;
            bus.err_fatal_mask = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
            for (int s = 0; s < NUM_ERR; s++) bus.err_info[s*INFO_W +: INFO_W] = 28'($urandom);
            bus.log_rd    = ($urandom_range(0, 2) == 0);
            bus.err_clear = ($urandom_range(0, 15) == 0);
            rst           = (c == 120);
            step();
        end
        rst = 0; bus.err_vec = '0; bus.log_rd = 0; bus.err_clear = 0;
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
